// File: rtl/execute_cycle.sv
// Execute stage: single-cycle ALU, optional 32-step restoring divider and the EX/MEM register.
// Define EXEC_DIV_EN to build the divider; without it ops 11-14 are reported as illegal.
module execute_cycle (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ex_valid_i,
    input  logic [3:0]  alu_op_i,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] rs2_data_i,
    input  logic [31:0] imm_i,
    input  logic        use_imm_i,
    input  logic [4:0]  rd_addr_i,
    input  logic        rd_wren_i,
    input  logic        mem_load_i,
    input  logic        mem_wren_i,
    input  logic        mem_unsign_i,
    input  logic [1:0]  mem_size_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic [31:0] result_m_o,
    output logic [31:0] rs2_data_m_o,
    output logic [4:0]  rd_addr_m_o,
    output logic        rd_wren_m_o,
    output logic        mem_load_m_o,
    output logic        mem_wren_m_o,
    output logic        mem_unsign_m_o,
    output logic [1:0]  mem_size_m_o,
    output logic        illegal_op_o
);

    localparam logic [3:0] OpAdd   = 4'd0;
    localparam logic [3:0] OpSub   = 4'd1;
    localparam logic [3:0] OpSll   = 4'd2;
    localparam logic [3:0] OpSlt   = 4'd3;
    localparam logic [3:0] OpSltu  = 4'd4;
    localparam logic [3:0] OpXor   = 4'd5;
    localparam logic [3:0] OpSrl   = 4'd6;
    localparam logic [3:0] OpSra   = 4'd7;
    localparam logic [3:0] OpOr    = 4'd8;
    localparam logic [3:0] OpAnd   = 4'd9;
    localparam logic [3:0] OpPassB = 4'd10;
    localparam logic [3:0] OpDiv   = 4'd11;
    localparam logic [3:0] OpRem   = 4'd13;
    localparam logic [3:0] OpRemu  = 4'd14;
    localparam logic [3:0] OpRsvd  = 4'd15;

    logic [31:0] op_b;
    logic [31:0] alu_res;
    logic [31:0] div_res;
    logic        is_div_op;
    logic        illegal_op;
    logic        stall_raw;

    assign op_b      = use_imm_i ? imm_i : rs2_data_i;
    assign is_div_op = (alu_op_i >= OpDiv) && (alu_op_i <= OpRemu);

    always_comb begin
        alu_res = '0;
        case (alu_op_i)
            OpAdd:   alu_res = rs1_data_i + op_b;
            OpSub:   alu_res = rs1_data_i - op_b;
            OpSll:   alu_res = rs1_data_i << op_b[4:0];
            OpSlt:   alu_res = {31'd0, ($signed(rs1_data_i) < $signed(op_b))};
            OpSltu:  alu_res = {31'd0, (rs1_data_i < op_b)};
            OpXor:   alu_res = rs1_data_i ^ op_b;
            OpSrl:   alu_res = rs1_data_i >> op_b[4:0];
            OpSra:   alu_res = $unsigned($signed(rs1_data_i) >>> op_b[4:0]);
            OpOr:    alu_res = rs1_data_i | op_b;
            OpAnd:   alu_res = rs1_data_i & op_b;
            OpPassB: alu_res = op_b;
            default: alu_res = '0;
        endcase
    end

`ifdef EXEC_DIV_EN
    typedef enum logic [1:0] {StIdle, StBusy, StDone} div_state_e;

    div_state_e  state_q, state_d;
    logic [5:0]  count_q, count_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] dvsr_q, dvsr_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic        signed_op, a_neg, b_neg, div_zero, div_ovf;
    logic [31:0] abs_a, abs_b;
    logic [32:0] rem_shift, rem_diff;

    assign signed_op = (alu_op_i == OpDiv) || (alu_op_i == OpRem);
    assign a_neg     = signed_op & rs1_data_i[31];
    assign b_neg     = signed_op & op_b[31];
    assign abs_a     = a_neg ? -rs1_data_i : rs1_data_i;
    assign abs_b     = b_neg ? -op_b : op_b;
    assign div_zero  = (op_b == 32'd0);
    assign div_ovf   = signed_op && (rs1_data_i == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);
    // Partial remainder shifted by one dividend bit; bit 32 of the difference is the borrow.
    assign rem_shift = {rem_q, quo_q[31]};
    assign rem_diff  = rem_shift - {1'b0, dvsr_q};

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvsr_d    = dvsr_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        stall_raw = 1'b0;
        case (state_q)
            StIdle: begin
                if (ex_valid_i && is_div_op) begin
                    stall_raw = 1'b1;
                    count_d   = '0;
                    neg_quo_d = 1'b0;
                    neg_rem_d = 1'b0;
                    dvsr_d    = '0;
                    if (div_zero) begin
                        quo_d   = 32'hFFFF_FFFF;
                        rem_d   = rs1_data_i;
                        state_d = StDone;
                    end else if (div_ovf) begin
                        quo_d   = 32'h8000_0000;
                        rem_d   = '0;
                        state_d = StDone;
                    end else begin
                        quo_d     = abs_a;
                        rem_d     = '0;
                        dvsr_d    = abs_b;
                        neg_quo_d = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                        state_d   = StBusy;
                    end
                end
            end
            StBusy: begin
                stall_raw = 1'b1;
                quo_d     = {quo_q[30:0], ~rem_diff[32]};
                rem_d     = rem_diff[32] ? rem_shift[31:0] : rem_diff[31:0];
                count_d   = count_q + 6'd1;
                if (count_q == 6'd31) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (flush_i) begin
            state_d   = StIdle;
            stall_raw = 1'b0;
        end
    end

    always_comb begin
        if ((alu_op_i == OpRem) || (alu_op_i == OpRemu)) begin
            div_res = neg_rem_q ? -rem_q : rem_q;
        end else begin
            div_res = neg_quo_q ? -quo_q : quo_q;
        end
    end

    assign illegal_op = (alu_op_i == OpRsvd);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            count_q   <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvsr_q    <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvsr_q    <= dvsr_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end
`else
    assign stall_raw  = 1'b0;
    assign div_res    = '0;
    assign illegal_op = (alu_op_i == OpRsvd) || is_div_op;
`endif

    assign stall_o = stall_raw & ~rst_i;

    logic        advance, capture;
    logic [31:0] result_d, rs2_data_d;
    logic [4:0]  rd_addr_d;
    logic        rd_wren_d, mem_load_d, mem_wren_d, mem_unsign_d, illegal_d;
    logic [1:0]  mem_size_d;

    assign advance = ex_valid_i & ~flush_i & ~stall_o;
    assign capture = advance & ~illegal_op;

    // Anything that does not advance, or is illegal, is loaded as an all-zero bubble.
    always_comb begin
        result_d     = '0;
        rs2_data_d   = '0;
        rd_addr_d    = '0;
        rd_wren_d    = 1'b0;
        mem_load_d   = 1'b0;
        mem_wren_d   = 1'b0;
        mem_unsign_d = 1'b0;
        mem_size_d   = '0;
        illegal_d    = advance & illegal_op;
        if (capture) begin
            result_d     = is_div_op ? div_res : alu_res;
            rs2_data_d   = rs2_data_i;
            rd_addr_d    = rd_addr_i;
            rd_wren_d    = rd_wren_i;
            mem_load_d   = mem_load_i;
            mem_wren_d   = mem_wren_i;
            mem_unsign_d = mem_unsign_i;
            mem_size_d   = mem_size_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            result_m_o     <= '0;
            rs2_data_m_o   <= '0;
            rd_addr_m_o    <= '0;
            rd_wren_m_o    <= 1'b0;
            mem_load_m_o   <= 1'b0;
            mem_wren_m_o   <= 1'b0;
            mem_unsign_m_o <= 1'b0;
            mem_size_m_o   <= '0;
            illegal_op_o   <= 1'b0;
        end else begin
            result_m_o     <= result_d;
            rs2_data_m_o   <= rs2_data_d;
            rd_addr_m_o    <= rd_addr_d;
            rd_wren_m_o    <= rd_wren_d;
            mem_load_m_o   <= mem_load_d;
            mem_wren_m_o   <= mem_wren_d;
            mem_unsign_m_o <= mem_unsign_d;
            mem_size_m_o   <= mem_size_d;
            illegal_op_o   <= illegal_d;
        end
    end

endmodule

// File: doc/execute_cycle.md
EXECUTE_CYCLE -- requirements
Module: execute_cycle

Interface
REQ-001 clk_i  in  1  single clock; all state updates on the rising edge.
REQ-002 rst_i  in  1  asynchronous, active-high reset.
REQ-003 ex_valid_i  in  1  decode presents a valid instruction.
REQ-004 alu_op_i  in  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB, 11 DIV, 12 DIVU, 13 REM, 14 REMU, 15 reserved.
REQ-005 rs1_data_i, rs2_data_i, imm_i  in  32 each  forwarded operands and immediate.
REQ-006 use_imm_i  in  1  operand B = imm_i when 1, rs2_data_i when 0.
REQ-007 rd_addr_i  in  5 ; rd_wren_i, mem_load_i, mem_wren_i, mem_unsign_i  in  1 ; mem_size_i  in  2  control signals carried to the memory stage.
REQ-008 flush_i  in  1  kill the instruction currently in execute.
REQ-009 stall_o  out  1  upstream must hold every input stable while this is high.
REQ-010 result_m_o, rs2_data_m_o  out  32 ; rd_addr_m_o  out  5 ; rd_wren_m_o, mem_load_m_o, mem_wren_m_o, mem_unsign_m_o  out  1 ; mem_size_m_o  out  2  EX/MEM pipeline register.
REQ-011 illegal_op_o  out  1  registered pulse for op 15, or for a divide op when the divider is compiled out.

Function
REQ-012 Non-divide ops SHALL use a single-cycle combinational ALU; RV32I semantics; shift amount is B[4:0].
REQ-013 SLT/SLTU SHALL produce 32'd1 or 32'd0; op 15 SHALL produce result 0 with all write/memory enables cleared.
REQ-014 The EX/MEM register SHALL capture the ALU result and all control signals on every edge where the stage advances; rs2_data_m_o SHALL be rs2_data_i regardless of use_imm_i.
REQ-015 A bubble SHALL clear rd_wren_m_o, mem_load_m_o and mem_wren_m_o and set result_m_o to 0. A bubble SHALL be loaded when ex_valid_i=0, stall_o=1, or flush_i=1.
REQ-016 Divider FSM states SHALL be IDLE, BUSY and DONE.
REQ-017 In IDLE, with a valid divide op, stall_o SHALL be 1 combinationally; the next edge SHALL load the operands (absolute values for signed ops) and enter BUSY with a 6-bit count of 0.
REQ-018 BUSY SHALL perform one restoring-division step per cycle for 32 cycles with stall_o=1, then enter DONE.
REQ-019 In DONE, stall_o SHALL be 0 and the sign-corrected quotient or remainder SHALL be captured into EX/MEM; the FSM SHALL then return to IDLE.
REQ-020 Total stall for a normal divide SHALL be 33 cycles, and the result SHALL be visible at result_m_o 34 cycles after the op is first presented.
REQ-021 Divide by zero SHALL go directly from IDLE to DONE (1 stall cycle): quotient 32'hFFFFFFFF, remainder = dividend.
REQ-022 Signed overflow (32'h80000000 / -1) SHALL go directly from IDLE to DONE: quotient 32'h80000000, remainder 0.
REQ-023 Signed results: quotient is negated when operand signs differ; remainder takes the sign of the dividend.
REQ-024 flush_i SHALL take priority over stall: FSM forced to IDLE, bubble loaded, stall_o forced to 0 in that cycle.
REQ-025 When not stalled, back-to-back divide ops SHALL each restart from IDLE; no divider state is reused between ops.

Reset
REQ-026 While rst_i is high, all EX/MEM outputs and illegal_op_o SHALL be 0, the FSM SHALL be IDLE, and the count and divider registers SHALL be 0.
REQ-027 Reset asserted during BUSY SHALL abandon the divide; stall_o SHALL be 0 while rst_i is high.

Configuration
REQ-028 Macro EXEC_DIV_EN defined: the divider and FSM are present as specified above.
REQ-029 Macro EXEC_DIV_EN undefined: no divider logic; ops 11-14 are handled as op 15 (bubble, illegal_op_o pulse); stall_o is tied to 0.

Verification
REQ-030 ADD with rs1=7, imm=-3, use_imm_i=1 -> next edge result_m_o=4, rd_wren_m_o=1, stall_o never asserted.
REQ-031 DIV with rs1=-20, rs2=3 -> stall_o high for exactly 33 cycles, then result_m_o=32'hFFFFFFFA; REM of the same operands -> 32'hFFFFFFFE.
REQ-032 DIVU with rs2=0, rs1=5 -> stall_o high for 1 cycle, result 32'hFFFFFFFF; REMU -> 5.
REQ-033 DIV 32'h80000000 / 32'hFFFFFFFF -> result 32'h80000000 after 1 stall cycle.
REQ-034 flush_i pulsed at BUSY count 10 -> stall_o drops in that cycle, a bubble is loaded, and a following ADD completes in 1 cycle.
REQ-035 rst_i pulsed mid-BUSY -> all outputs 0, FSM IDLE; build without EXEC_DIV_EN and issue DIV -> illegal_op_o=1 for one cycle and a bubble is loaded.
